cp0_unit: RTL and testbench



---
 rtl/cp0_pkg.sv | 62 ++++++
 rtl/cp0_unit_if.sv | 28 ++
 rtl/cp0_count_timer.sv | 40 ++++
 rtl/cp0_unit.sv | 117 +++++++++++
 tb/tb_cp0_unit.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/cp0_pkg.sv
// cp0_pkg -- shared definitions for the coprocessor-0 slice.
//   Register numbers, exception codes, SR/Cause field positions and
//   the packed views of SR and Cause as seen by mfc0.
package cp0_pkg;

   // CP0 register numbers
   localparam logic [4:0] REG_COUNT   = 5'd9;
   localparam logic [4:0] REG_COMPARE = 5'd11;
   localparam logic [4:0] REG_SR      = 5'd12;
   localparam logic [4:0] REG_CAUSE   = 5'd13;
   localparam logic [4:0] REG_EPC     = 5'd14;
   localparam logic [4:0] REG_PRID    = 5'd15;

   // Exception codes; INT (0) also means "no synchronous exception"
   typedef enum logic [4:0] {
      EXC_INT  = 5'd0,
      EXC_ADEL = 5'd4,
      EXC_ADES = 5'd5,
      EXC_RI   = 5'd10,
      EXC_OV   = 5'd12
   } exc_code_e;

   // Field positions
   localparam int SR_IM_LSB     = 10;
   localparam int SR_EXL        = 1;
   localparam int SR_IE         = 0;
   localparam int CAUSE_BD      = 31;
   localparam int CAUSE_IP_LSB  = 10;
   localparam int CAUSE_EXC_LSB = 2;

   typedef struct packed {
      logic [5:0] im;
      logic       exl;
      logic       ie;
   } sr_t;

   typedef struct packed {
      logic       bd;
      logic [5:0] ip;
      logic [4:0] exc_code;
   } cause_t;

   // Place SR fields at their architectural bit positions; rest read 0
   function automatic logic [31:0] pack_sr(sr_t s);
      logic [31:0] r;
      r = '0;
      r[SR_IM_LSB +: 6] = s.im;
      r[SR_EXL]         = s.exl;
      r[SR_IE]          = s.ie;
      return r;
   endfunction

   function automatic logic [31:0] pack_cause(cause_t c);
      logic [31:0] r;
      r = '0;
      r[CAUSE_BD]            = c.bd;
      r[CAUSE_IP_LSB +: 6]   = c.ip;
      r[CAUSE_EXC_LSB +: 5]  = c.exc_code;
      return r;
   endfunction

endpackage

// File: rtl/cp0_unit_if.sv
// cp0_unit_if -- pipeline <-> CP0 signal bundle.
//   slave  : CP0 side (consumes M-stage info, produces Dout/EPCOut/HandlerPC/Req)
//   master : pipeline side
interface cp0_unit_if;
   logic [4:0]  RdAddr;
   logic [4:0]  WrAddr;
   logic [31:0] Din;
   logic        WE;
   logic [31:0] VPC;
   logic        BDIn;
   logic [4:0]  ExcCodeIn;
   logic [5:0]  HWInt;
   logic        EXLClr;
   logic [31:0] Dout;
   logic [31:0] EPCOut;
   logic [31:0] HandlerPC;
   logic        Req;

   modport slave (
      input  RdAddr, WrAddr, Din, WE, VPC, BDIn, ExcCodeIn, HWInt, EXLClr,
      output Dout, EPCOut, HandlerPC, Req
   );

   modport master (
      output RdAddr, WrAddr, Din, WE, VPC, BDIn, ExcCodeIn, HWInt, EXLClr,
      input  Dout, EPCOut, HandlerPC, Req
   );
endinterface

// File: rtl/cp0_count_timer.sv
// cp0_count_timer -- Count/Compare timer (built only with CP0_COUNT_EN).
//   clk, reset     : clock, async active-low reset
//   wr_count       : load Count from din instead of incrementing
//   wr_compare     : load Compare from din, clears the pending timer
//   din            : mtc0 write data
//   count, compare : register contents for mfc0
//   timer_pend     : timer interrupt pending (visible in the matching cycle)
module cp0_count_timer (
   input  logic        clk,
   input  logic        reset,
   input  logic        wr_count,
   input  logic        wr_compare,
   input  logic [31:0] din,
   output logic [31:0] count,
   output logic [31:0] compare,
   output logic        timer_pend
);

   logic [31:0] count_q, compare_q;
   logic        pend_q;

   // The match is ORed in combinationally so the request appears in the
   // very cycle Count equals Compare; pend_q holds it afterwards.
   assign timer_pend = pend_q | (count_q == compare_q);
   assign count      = count_q;
   assign compare    = compare_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q   <= '0;
         compare_q <= '0;
         pend_q    <= 1'b0;
      end else begin
         count_q   <= wr_count ? din : count_q + 32'd1;
         if (wr_compare) compare_q <= din;
         pend_q    <= wr_compare ? 1'b0 : timer_pend;
      end
   end

endmodule

// File: rtl/cp0_unit.sv
// cp0_unit -- M-stage coprocessor 0: SR, Cause, EPC, PRId; mfc0/mtc0/eret;
//             interrupt/exception request generation.
//   clk    : clock, rising edge
//   reset  : asynchronous, active-low
//   bus    : cp0_unit_if.slave (RdAddr/WrAddr/Din/WE, VPC/BDIn/ExcCodeIn,
//            HWInt, EXLClr in; Dout, EPCOut, HandlerPC, Req out)
//   Optional: define CP0_COUNT_EN to add Count(9)/Compare(11) with a timer
//   interrupt merged into HWInt[5].
module cp0_unit
   import cp0_pkg::*;
#(
   parameter logic [31:0] PRID_VALUE = 32'h0000_2023,
   parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
   input  logic       clk,
   input  logic       reset,
   cp0_unit_if.slave  bus
);

   sr_t         sr_q;
   cause_t      cause_q;
   logic [31:0] epc_q;

   logic [5:0]  hw_eff;
   logic        int_req, exc_req, req;
   logic        wr_en;

   // A write in the same cycle as a taken exception is discarded
   assign wr_en = bus.WE & ~req;

`ifdef CP0_COUNT_EN
   logic [31:0] count, compare;
   logic        timer_pend;

   cp0_count_timer u_timer (
      .clk        (clk),
      .reset      (reset),
      .wr_count   (wr_en && bus.WrAddr == REG_COUNT),
      .wr_compare (wr_en && bus.WrAddr == REG_COMPARE),
      .din        (bus.Din),
      .count      (count),
      .compare    (compare),
      .timer_pend (timer_pend)
   );

   assign hw_eff = {bus.HWInt[5] | timer_pend, bus.HWInt[4:0]};
`else
   assign hw_eff = bus.HWInt;
`endif

   assign int_req = (|(hw_eff & sr_q.im)) & sr_q.ie & ~sr_q.exl;
   assign exc_req = (bus.ExcCodeIn != EXC_INT) & ~sr_q.exl;
   assign req     = int_req | exc_req;

   assign bus.Req       = req;
   assign bus.EPCOut    = epc_q;
   assign bus.HandlerPC = HANDLER_PC;

   // SR: exception entry sets EXL; otherwise mtc0 first, then eret clears
   // EXL, so an mtc0 to SR together with eret leaves EXL at 0.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sr_q <= '0;
      end else if (req) begin
         sr_q.exl <= 1'b1;
      end else begin
         if (wr_en && bus.WrAddr == REG_SR) begin
            sr_q.im  <= bus.Din[SR_IM_LSB +: 6];
            sr_q.exl <= bus.Din[SR_EXL];
            sr_q.ie  <= bus.Din[SR_IE];
         end
         if (bus.EXLClr) sr_q.exl <= 1'b0;
      end
   end

   // Cause: IP tracks the (merged) interrupt lines every cycle; BD and
   // ExcCode only change on exception entry. Not writable by mtc0.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cause_q <= '0;
      end else begin
         cause_q.ip <= hw_eff;
         if (req) begin
            cause_q.bd       <= bus.BDIn;
            cause_q.exc_code <= int_req ? EXC_INT : bus.ExcCodeIn;
         end
      end
   end

   // EPC: delay-slot instructions restart at the branch (VPC-4, wrapping)
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         epc_q <= '0;
      end else if (req) begin
         epc_q <= bus.BDIn ? bus.VPC - 32'd4 : bus.VPC;
      end else if (wr_en && bus.WrAddr == REG_EPC) begin
         epc_q <= bus.Din;
      end
   end

   // mfc0 returns pre-edge contents; no write bypass
   always_comb begin
      bus.Dout = '0;
      case (bus.RdAddr)
         REG_SR:      bus.Dout = pack_sr(sr_q);
         REG_CAUSE:   bus.Dout = pack_cause(cause_q);
         REG_EPC:     bus.Dout = epc_q;
         REG_PRID:    bus.Dout = PRID_VALUE;
`ifdef CP0_COUNT_EN
         REG_COUNT:   bus.Dout = count;
         REG_COMPARE: bus.Dout = compare;
`endif
         default:     bus.Dout = '0;
      endcase
   end

endmodule

// File: tb/tb_cp0_unit.sv
// tb_cp0_unit -- self-checking bench for cp0_unit: directed scenarios plus
// randomized M-stage traffic compared against a register-level model.
// Define CP0_COUNT_EN for both RTL and bench to cover the timer.
module tb_cp0_unit;
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   cp0_unit_if bus();

   cp0_unit #(
      .PRID_VALUE (32'h0000_2023),
      .HANDLER_PC (32'h0000_4180)
   ) dut (
      .clk   (clk),
      .reset (rst_n),
      .bus   (bus)
   );

   int n_vec = 0;
   int n_err = 0;

   // reference model state (architectural fields)
   logic [5:0]  m_im;
   logic        m_exl, m_ie, m_bd;
   logic [5:0]  m_ip;
   logic [4:0]  m_exc;
   logic [31:0] m_epc;
`ifdef CP0_COUNT_EN
   logic [31:0] m_cnt, m_cmp;
   logic        m_pend;
`endif

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic m_reset();
      m_im = '0; m_exl = 0; m_ie = 0; m_bd = 0; m_ip = '0; m_exc = '0; m_epc = '0;
`ifdef CP0_COUNT_EN
      m_cnt = '0; m_cmp = '0; m_pend = 0;
`endif
   endtask

   function automatic logic [5:0] m_hw();
`ifdef CP0_COUNT_EN
      logic p;
      p = m_pend || (m_cnt == m_cmp);
      return bus.HWInt | {p, 5'b0};
`else
      return bus.HWInt;
`endif
   endfunction

   function automatic logic m_int();
      return ((m_hw() & m_im) != 0) && m_ie && !m_exl;
   endfunction

   function automatic logic m_req();
      return m_int() || (bus.ExcCodeIn != 0 && !m_exl);
   endfunction

   function automatic logic [31:0] m_read(input logic [4:0] a);
      case (a)
         5'd12: return {16'b0, m_im, 8'b0, m_exl, m_ie};
         5'd13: return {m_bd, 15'b0, m_ip, 3'b0, m_exc, 2'b0};
         5'd14: return m_epc;
         5'd15: return 32'h0000_2023;
`ifdef CP0_COUNT_EN
         5'd9:  return m_cnt;
         5'd11: return m_cmp;
`endif
         default: return 32'h0;
      endcase
   endfunction

   task automatic idle();
      bus.RdAddr = 0; bus.WrAddr = 0; bus.Din = 0; bus.WE = 0; bus.VPC = 0;
      bus.BDIn = 0; bus.ExcCodeIn = 0; bus.HWInt = 0; bus.EXLClr = 0;
   endtask

   // Called just after a negedge with inputs driven: check outputs against
   // the model, cross the rising edge, advance the model.
   task automatic cyc();
      logic ir, rq, wr;
      logic [5:0] hw;
      #1;
      chk("req",     {31'b0, bus.Req}, {31'b0, m_req()});
      chk("dout",    bus.Dout, m_read(bus.RdAddr));
      chk("epc_out", bus.EPCOut, m_epc);
      chk("handler", bus.HandlerPC, 32'h0000_4180);
      @(posedge clk);
      ir = m_int(); rq = m_req(); hw = m_hw();
      wr = bus.WE && !rq;
`ifdef CP0_COUNT_EN
      begin
         logic p;
         p = m_pend || (m_cnt == m_cmp);
         m_cnt  = (wr && bus.WrAddr == 9) ? bus.Din : m_cnt + 1;
         if (wr && bus.WrAddr == 11) m_cmp = bus.Din;
         m_pend = (wr && bus.WrAddr == 11) ? 1'b0 : p;
      end
`endif
      m_ip = hw;
      if (rq) begin
         m_exl = 1; m_bd = bus.BDIn;
         m_epc = bus.BDIn ? bus.VPC - 32'd4 : bus.VPC;
         m_exc = ir ? 5'd0 : bus.ExcCodeIn;
      end else begin
         if (wr && bus.WrAddr == 12) begin
            m_im = bus.Din[15:10]; m_exl = bus.Din[1]; m_ie = bus.Din[0];
         end
         if (wr && bus.WrAddr == 14) m_epc = bus.Din;
         if (bus.EXLClr) m_exl = 0;
      end
      @(negedge clk);
   endtask

   initial begin
      logic [4:0] addrs [7];
      logic [4:0] excs [5];
      addrs = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd3};
      excs  = '{5'd4, 5'd5, 5'd10, 5'd12, 5'd1};
      idle();
      m_reset();

      // reset state while reset is held low
      #2;
      chk("rst_req", {31'b0, bus.Req}, 32'h0);
      bus.RdAddr = 12; #1 chk("rst_sr", bus.Dout, 32'h0);
      bus.RdAddr = 13; #1 chk("rst_cause", bus.Dout, 32'h0);
      bus.RdAddr = 14; #1 chk("rst_epc", bus.Dout, 32'h0);
      bus.RdAddr = 15; #1 chk("prid", bus.Dout, 32'h0000_2023);
      @(negedge clk);
      rst_n = 1'b1;

      // interrupt: IM[10] + IE, TC0 line
      idle(); bus.WE = 1; bus.WrAddr = 12; bus.Din = 32'h0000_0401; cyc();
      idle(); bus.HWInt = 6'b000001; bus.VPC = 32'h0000_3010;
      #1 chk("int_req", {31'b0, bus.Req}, 32'h1);
      cyc();
      idle(); bus.RdAddr = 14; #1 chk("int_epc", bus.Dout, 32'h0000_3010);
      bus.RdAddr = 13; #1 chk("int_cause", bus.Dout, 32'h0000_0400);
      bus.RdAddr = 12; #1 chk("int_exl", bus.Dout, 32'h0000_0403);
      cyc();

      // mtc0 SR together with eret: EXL ends 0
      idle(); bus.WE = 1; bus.WrAddr = 12; bus.Din = 32'h0000_FC03; bus.EXLClr = 1; cyc();
      // overflow in a delay slot
      idle(); bus.ExcCodeIn = 12; bus.BDIn = 1; bus.VPC = 32'h0000_3024;
      #1 chk("ov_req", {31'b0, bus.Req}, 32'h1);
      cyc();
      idle(); bus.RdAddr = 14; #1 chk("ov_epc", bus.Dout, 32'h0000_3020);
      bus.RdAddr = 13; #1 chk("ov_cause", bus.Dout, 32'h8000_0030);
      cyc();

      // EXL masks interrupt; IP still tracks; eret re-enables
      idle(); bus.HWInt = 6'b000100; bus.RdAddr = 13;
      #1 chk("exl_mask", {31'b0, bus.Req}, 32'h0);
      cyc();
      idle(); bus.HWInt = 6'b000100; bus.RdAddr = 13;
      #1 chk("ip_track", {29'b0, bus.Dout[12:10]}, 32'h4);
      bus.EXLClr = 1; cyc();
      // write to EPC loses against the request
      idle(); bus.HWInt = 6'b000100; bus.WE = 1; bus.WrAddr = 14;
      bus.Din = 32'h1234_5678; bus.VPC = 32'h0000_3000;
      #1 chk("eret_req", {31'b0, bus.Req}, 32'h1);
      cyc();
      idle(); bus.RdAddr = 14; #1 chk("we_vs_req", bus.Dout, 32'h0000_3000);
      cyc();

      // reset asserted mid-handler clears everything at once
      idle(); bus.RdAddr = 12; #2;
      rst_n = 1'b0; m_reset();
      #1 chk("midrst_sr", bus.Dout, 32'h0);
      chk("midrst_epc", bus.EPCOut, 32'h0);
      chk("midrst_req", {31'b0, bus.Req}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

`ifdef CP0_COUNT_EN
      begin
         bit seen;
         seen = 0;
         idle(); bus.WE = 1; bus.WrAddr = 11; bus.Din = 32'd10; cyc();
         idle(); bus.WE = 1; bus.WrAddr = 12; bus.Din = 32'h0000_8001; cyc();
         for (int i = 0; i < 20 && !seen; i++) begin
            idle(); bus.RdAddr = 9; #1;
            if (bus.Req) begin
               seen = 1;
               chk("timer_at", bus.Dout, 32'd10);
            end
            cyc();
         end
         chk("timer_seen", {31'b0, seen}, 32'h1);
         idle(); bus.WE = 1; bus.WrAddr = 11; bus.Din = 32'd100000; cyc();
         idle(); bus.EXLClr = 1; cyc();
         idle(); #1 chk("timer_clr", {31'b0, bus.Req}, 32'h0);
         cyc();
      end
`endif

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         idle();
         bus.RdAddr = addrs[$urandom_range(0, 6)];
         if ($urandom_range(0, 2) == 0) begin
            bus.WE = 1;
            bus.WrAddr = addrs[$urandom_range(0, 6)];
         end
         bus.Din = $urandom;
         bus.VPC = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 7)) : $urandom;
         bus.BDIn = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 3) == 0) bus.ExcCodeIn = excs[$urandom_range(0, 4)];
         if ($urandom_range(0, 2) == 0) bus.HWInt = 6'($urandom);
         bus.EXLClr = ($urandom_range(0, 7) == 0);
         cyc();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
